// File: rtl/fpu_op_sched_if.sv
// Bus bundle for the FPU operation scheduler: command intake, unit start/done,
// encoder control/return, response channel, status and a state debug tap.
// Handshake rule: a transfer on cmd_* or rsp_* happens on the rising edge
// where valid and ready are both high; valid holds its payload stable until
// that edge, and ready may change freely.
interface fpu_op_sched_if #(
    parameter int OPERAND_WIDTH = 32,
    parameter int TAG_WIDTH     = 4
);
    logic                     cmd_valid_i;
    logic                     cmd_ready_o;
    logic [2:0]               cmd_op_i;
    logic [2:0]               cmd_rnd_i;
    logic [TAG_WIDTH-1:0]     cmd_tag_i;
    logic [4:0]               unit_start_o;
    logic [4:0]               unit_done_i;
    logic [2:0]               fpu_round_mode_o;
    logic                     fpu_enc_en_o;
    logic                     fpu_enc_ready_i;
    logic [OPERAND_WIDTH-1:0] fpu_result_i;
    logic [4:0]               fpu_flags_i;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [OPERAND_WIDTH-1:0] rsp_result_o;
    logic [4:0]               rsp_flags_o;
    logic [TAG_WIDTH-1:0]     rsp_tag_o;
    logic                     busy_o;
    logic                     err_o;
    logic [2:0]               dbg_state_o;

    // Scheduler side
    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_rnd_i, cmd_tag_i, unit_done_i,
               fpu_enc_ready_i, fpu_result_i, fpu_flags_i, rsp_ready_i,
        output cmd_ready_o, unit_start_o, fpu_round_mode_o, fpu_enc_en_o,
               rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_tag_o, busy_o,
               err_o, dbg_state_o
    );

    // Environment side (command source, units, encoder, response sink)
    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_rnd_i, cmd_tag_i, unit_done_i,
               fpu_enc_ready_i, fpu_result_i, fpu_flags_i, rsp_ready_i,
        input  cmd_ready_o, unit_start_o, fpu_round_mode_o, fpu_enc_en_o,
               rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_tag_o, busy_o,
               err_o, dbg_state_o
    );
endinterface

// File: rtl/fpu_op_sched.sv
// FPU operation scheduler: 2-entry command FIFO feeding a single-issue FSM
// (IDLE/ISSUE/WAIT/ENCODE/RESP). One command in flight, in-order responses.
// Optional macro FPU_SCHED_TIMEOUT_EN adds a WAIT watchdog with sticky err_o.
module fpu_op_sched #(
    parameter int OPERAND_WIDTH  = 32,
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          fpu_clk,
    input  logic          fpu_rst_n,
    fpu_op_sched_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_ENCODE = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [31:0] LP_NAN_RESULT = 32'h7FC0_0000;
    localparam logic [4:0]  LP_NAN_FLAGS  = 5'b10000;

    state_t                        r_state;
    logic [1:0][2:0]               r_fifo_op;
    logic [1:0][2:0]               r_fifo_rnd;
    logic [1:0][TAG_WIDTH-1:0]     r_fifo_tag;
    logic                          r_wr_ptr;
    logic                          r_rd_ptr;
    logic [1:0]                    r_count;
    logic [2:0]                    r_act_op;
    logic [TAG_WIDTH-1:0]          r_act_tag;
    logic [4:0]                    r_start;
    logic [2:0]                    r_round;
    logic                          r_enc_en;
    logic                          r_rsp_valid;
    logic [OPERAND_WIDTH-1:0]      r_rsp_result;
    logic [4:0]                    r_rsp_flags;

    logic                          w_full;
    logic                          w_empty;
    logic                          w_push;
    logic                          w_pop;
    logic [2:0]                    w_head_op;
    logic                          w_head_bad;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign w_full     = (r_count == 2'd2);
    assign w_empty    = (r_count == 2'd0);
    assign w_push     = bus.cmd_valid_i && !w_full;
    assign w_pop      = !w_empty && ((r_state == S_IDLE) ||
                                     (r_state == S_RESP && bus.rsp_ready_i));
    assign w_head_op  = r_fifo_op[r_rd_ptr];
    assign w_head_bad = (w_head_op > 3'd4);

    // Command FIFO storage, pointers and occupancy.
    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            r_fifo_op  <= '0;
            r_fifo_rnd <= '0;
            r_fifo_tag <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_op[r_wr_ptr]  <= bus.cmd_op_i;
                r_fifo_rnd[r_wr_ptr] <= bus.cmd_rnd_i;
                r_fifo_tag[r_wr_ptr] <= bus.cmd_tag_i;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FPU_SCHED_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_err;
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

    // Scheduler FSM with all control outputs registered.
    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            r_state      <= S_IDLE;
            r_act_op     <= '0;
            r_act_tag    <= '0;
            r_start      <= '0;
            r_round      <= '0;
            r_enc_en     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
`ifdef FPU_SCHED_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_start <= '0;
            if (w_pop) begin
                // Dispatch the FIFO head; illegal opcodes answer immediately with qNaN.
                r_act_op  <= w_head_op;
                r_act_tag <= r_fifo_tag[r_rd_ptr];
                if (w_head_bad) begin
                    r_state      <= S_RESP;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= OPERAND_WIDTH'(LP_NAN_RESULT);
                    r_rsp_flags  <= LP_NAN_FLAGS;
                    r_round      <= '0;
                end else begin
                    r_state     <= S_ISSUE;
                    r_rsp_valid <= 1'b0;
                    r_start     <= 5'b00001 << w_head_op;
                    r_round     <= r_fifo_rnd[r_rd_ptr];
                end
            end else begin
                case (r_state)
                    S_ISSUE: begin
                        r_state <= S_WAIT;
`ifdef FPU_SCHED_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                    S_WAIT: begin
                        if (bus.unit_done_i[r_act_op]) begin
                            r_state  <= S_ENCODE;
                            r_enc_en <= 1'b1;
`ifdef FPU_SCHED_TIMEOUT_EN
                        end else if (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                            r_state      <= S_RESP;
                            r_round      <= '0;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_result <= OPERAND_WIDTH'(LP_NAN_RESULT);
                            r_rsp_flags  <= LP_NAN_FLAGS;
                            r_err        <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
                        end
                    end
                    S_ENCODE: begin
                        if (bus.fpu_enc_ready_i) begin
                            r_state      <= S_RESP;
                            r_enc_en     <= 1'b0;
                            r_round      <= '0;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_result <= bus.fpu_result_i;
                            r_rsp_flags  <= bus.fpu_flags_i;
                        end
                    end
                    S_RESP: begin
                        if (bus.rsp_ready_i) begin
                            r_state     <= S_IDLE;
                            r_rsp_valid <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef FPU_SCHED_TIMEOUT_EN
    assign bus.err_o = r_err;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.cmd_ready_o      = !w_full;
    assign bus.unit_start_o     = r_start;
    assign bus.fpu_round_mode_o = r_round;
    assign bus.fpu_enc_en_o     = r_enc_en;
    assign bus.rsp_valid_o      = r_rsp_valid;
    assign bus.rsp_result_o     = r_rsp_result;
    assign bus.rsp_flags_o      = r_rsp_flags;
    assign bus.rsp_tag_o        = r_act_tag;
    assign bus.busy_o           = (r_state != S_IDLE) || !w_empty;
    assign bus.dbg_state_o      = r_state;
endmodule
